// File: rtl/load_store_ctrl.sv
// load_store_ctrl: RV64I load/store sequencer with a req/ack data-memory handshake.
// Optional LSC_MISALIGN_TRAP_EN: trap misaligned accesses (cause 01) instead of aligning them down.
module load_store_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [63:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);
  localparam int unsigned CNT_W = 32;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;
  state_t state, next_state;

  logic [2:0]       f3_q;
  logic [2:0]       off_q;
  logic [CNT_W-1:0] wd_cnt;

  logic        is_load_c, is_store_c, illegal_c, timeout_c;
  logic [2:0]  size_m1_c, off_c;
  logic [7:0]  lane_mask_c;
  logic [1:0]  cause_c;
  logic [63:0] shifted_c, ext_c;

  // decode of the incoming request; off_c is the offset after alignment fix-up
  always_comb begin
    is_load_c  = (opcode == OP_LOAD);
    is_store_c = (opcode == OP_STORE);
    illegal_c  = !(is_load_c && (funct3 != 3'b111)) && !(is_store_c && !funct3[2]);
    case (funct3[1:0])
      2'd0:    begin size_m1_c = 3'd0; lane_mask_c = 8'h01; end
      2'd1:    begin size_m1_c = 3'd1; lane_mask_c = 8'h03; end
      2'd2:    begin size_m1_c = 3'd3; lane_mask_c = 8'h0F; end
      default: begin size_m1_c = 3'd7; lane_mask_c = 8'hFF; end
    endcase
    off_c = addr[2:0] & ~size_m1_c;
  end

`ifdef LSC_MISALIGN_TRAP_EN
  logic misalign_c;
  assign misalign_c = |(addr[2:0] & size_m1_c);
`endif

  assign timeout_c = (TIMEOUT != 0) && (wd_cnt == CNT_W'(TIMEOUT - 1));

  // load alignment and extension
  always_comb begin
    shifted_c = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext_c = {{56{shifted_c[7]}},  shifted_c[7:0]};
      3'b001:  ext_c = {{48{shifted_c[15]}}, shifted_c[15:0]};
      3'b010:  ext_c = {{32{shifted_c[31]}}, shifted_c[31:0]};
      3'b100:  ext_c = {56'd0, shifted_c[7:0]};
      3'b101:  ext_c = {48'd0, shifted_c[15:0]};
      3'b110:  ext_c = {32'd0, shifted_c[31:0]};
      default: ext_c = shifted_c;
    endcase
  end

  always_comb begin
    next_state = state;
    cause_c    = 2'b00;
    case (state)
      IDLE: begin
        if (start) begin
          if (illegal_c) begin
            next_state = FAULT;
            cause_c    = CAUSE_ILLEGAL;
          end
`ifdef LSC_MISALIGN_TRAP_EN
          else if (misalign_c) begin
            next_state = FAULT;
            cause_c    = 2'b01;
          end
`endif
          else begin
            next_state = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          next_state = RESP;
        end else if (timeout_c) begin
          next_state = FAULT;
          cause_c    = CAUSE_TIMEOUT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      rdata       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      wd_cnt      <= '0;
    end else begin
      state       <= next_state;
      busy        <= (next_state != IDLE);
      done        <= (next_state == RESP) || (next_state == FAULT);
      fault       <= (next_state == FAULT);
      fault_cause <= cause_c;
      mem_req     <= (next_state == REQ);

      if (state == IDLE && start) begin
        f3_q  <= funct3;
        off_q <= off_c;
      end

      // bus fields are set on entry to REQ and held through the handshake
      if (state == IDLE && next_state == REQ) begin
        mem_we    <= is_store_c;
        mem_addr  <= {addr[63:3], 3'b000};
        mem_wdata <= is_store_c ? (wdata << {off_c, 3'b000}) : '0;
        mem_wmask <= is_store_c ? (lane_mask_c << off_c) : 8'h00;
      end else if (next_state != REQ) begin
        mem_we <= 1'b0;
      end

      if (state == REQ && next_state == REQ) wd_cnt <= wd_cnt + CNT_W'(1);
      else                                   wd_cnt <= '0;

      if (state == REQ && mem_ack && !mem_we) rdata <= ext_c;
    end
  end
endmodule

// File: tb/tb_load_store_ctrl.sv
// Scoreboarded random/directed bench for load_store_ctrl against a byte-level access model.
module tb_load_store_ctrl;
  localparam int unsigned TO = 4;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        busy, done, fault, mem_req, mem_we;
  logic [1:0]  fault_cause;
  logic [63:0] rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;

  load_store_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault),
    .fault_cause(fault_cause), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  typedef struct {
    logic        fault;
    logic [1:0]  cause;
    logic [63:0] rdata;
    int          t0;
    int          lat;
    int          req_len;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  logic [63:0] model_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // while the DUT is busy, wiggle start and the request fields; all of it must be ignored
  task automatic noise();
    if (busy) begin
      start  = 1'($urandom_range(0, 1));
      opcode = $urandom_range(0, 1) ? OP_LD : OP_ST;
      funct3 = 3'($urandom_range(0, 7));
      addr   = rand64();
      wdata  = rand64();
    end else begin
      start = 1'b0;
    end
  endtask

  // issue one access at a negedge with the DUT idle; delay = REQ cycle of the ack (outside 1..TO: none)
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] rd, input int delay);
    int size, off, nb, n;
    bit legal, trap, to_req, tmo;
    logic [63:0] v, m;
    req_t rq;
    rsp_t rs;
    legal = ((op == OP_LD) && (f3 != 3'd7)) || ((op == OP_ST) && (f3 < 3'd4));
    size  = 1 << f3[1:0];
    off   = int'(a[2:0]);
    trap  = 1'b0;
    if (off % size != 0) begin
`ifdef LSC_MISALIGN_TRAP_EN
      trap = 1'b1;
`else
      off = off - (off % size);
`endif
    end
    to_req = legal && !trap;
    tmo    = to_req && (delay < 1 || delay > int'(TO));
    if (!legal)     rs.cause = 2'b11;
    else if (trap)  rs.cause = 2'b01;
    else if (tmo)   rs.cause = 2'b10;
    else            rs.cause = 2'b00;
    rs.fault   = !to_req || tmo;
    rs.lat     = !to_req ? 1 : (tmo ? int'(TO) + 1 : delay + 1);
    rs.req_len = !to_req ? 0 : (tmo ? int'(TO) : delay);
    if (to_req && !tmo && op == OP_LD) begin
      nb = 8 * size;
      v  = rd >> (8 * off);
      m  = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
      v  = v & m;
      if (f3 < 3'd3 && v[nb-1]) v = v | ~m;
      model_rdata = v;
    end
    rs.rdata = model_rdata;
    rs.t0    = cyc;
    rq.we    = (op == OP_ST);
    rq.addr  = a & ~64'h7;
    rq.wdata = wd << (8 * off);
    rq.wmask = rq.we ? 8'(((1 << size) - 1) << off) : 8'h00;

    start = 1'b1; opcode = op; funct3 = f3; addr = a; wdata = wd;
    if (to_req) req_q.push_back(rq);
    rsp_q.push_back(rs);
    @(negedge clk);
    start = 1'b0;
    noise();
    if (to_req) begin
      for (int k = 1; k <= int'(TO); k++) begin
        if (k == delay) begin mem_ack = 1'b1; mem_rdata = rd; end
        else begin mem_ack = 1'b0; mem_rdata = rand64(); end
        @(negedge clk);
        noise();
        if (k == delay) break;
      end
      mem_ack = 1'b0;
      mem_rdata = rand64();
    end
    n = 0;
    while (busy && n < 20) begin
      noise();
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy) chk("busy_release_bound", 64'(busy), 64'd0);
  endtask

  // scoreboard monitor
  initial begin
    bit   prev_req = 1'b0;
    int   rl = 0;
    req_t rq;
    rsp_t rs;
    forever begin
      @(negedge clk);
      if (mem_req) rl++;
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) chk("unexpected_mem_req", 64'(mem_req), 64'd0);
        else begin
          rq = req_q.pop_front();
          chk("mem_we", 64'(mem_we), 64'(rq.we));
          chk("mem_addr", mem_addr, rq.addr);
          chk("mem_wmask", 64'(mem_wmask), 64'(rq.wmask));
          if (rq.we) chk("mem_wdata", mem_wdata, rq.wdata);
        end
      end
      if (done) begin
        if (rsp_q.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
        else begin
          rs = rsp_q.pop_front();
          chk("fault", 64'(fault), 64'(rs.fault));
          chk("fault_cause", 64'(fault_cause), 64'(rs.cause));
          chk("rdata", rdata, rs.rdata);
          chk("done_latency", 64'(cyc - rs.t0), 64'(rs.lat));
          chk("req_cycles", 64'(rl), 64'(rs.req_len));
        end
        rl = 0;
      end else if (!busy) begin
        rl = 0;
      end
      prev_req = mem_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int r, d;
    logic [6:0] op;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_cause", 64'(fault_cause), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(OP_LD, 3'b000, 64'h1003, rand64(), 64'h0000_0000_8000_0000, 1);
    chk("lb_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn(OP_LD, 3'b110, 64'h1004, rand64(), 64'hDEAD_BEEF_0000_0000, 3);
    chk("lwu_rdata", rdata, 64'h0000_0000_DEAD_BEEF);
    run_txn(OP_ST, 3'b001, 64'h1006, 64'h1234, rand64(), 2);
    chk("sh_rdata_held", rdata, 64'h0000_0000_DEAD_BEEF);
    run_txn(OP_LD, 3'b010, 64'h1002, rand64(), 64'h0123_4567_89AB_CDEF, 1);
    run_txn(OP_LD, 3'b111, 64'h1000, rand64(), rand64(), 1);
    run_txn(7'b0110011, 3'b000, 64'h1000, rand64(), rand64(), 1);

    // timeout followed by a late ack that must be ignored
    run_txn(OP_LD, 3'b011, 64'h3000, rand64(), rand64(), 0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = rand64();
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_busy", 64'(busy), 64'd0);
    chk("late_ack_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    chk("late_ack_done", 64'(done), 64'd0);

    // reset in the middle of REQ
    run_txn(OP_LD, 3'b000, 64'h1003, rand64(), 64'h0000_0000_8000_0000, 1);
    start = 1'b1; opcode = OP_LD; funct3 = 3'b011; addr = 64'h2000;
    req_q.push_back('{we: 1'b0, addr: 64'h2000, wdata: 64'd0, wmask: 8'h00});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 64'(mem_req), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_rdata = '0;
    chk("mid_rst_req", 64'(mem_req), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_rdata", rdata, 64'd0);
    repeat (3) @(negedge clk);
    run_txn(OP_LD, 3'b001, 64'h2006, rand64(), 64'h8001_0000_0000_0000, 2);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      op = (r < 9) ? OP_LD : ((r < 18) ? OP_ST : 7'($urandom()));
      d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
      run_txn(op, 3'($urandom_range(0, 7)), rand64(), rand64(), rand64(), d);
    end

    repeat (3) @(negedge clk);
    chk("req_q_drained", 64'(req_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
